// File: rtl/decode_dense_pipe_if.sv
// rtl/decode_dense_pipe_if.sv - handshake bus carrying the decode bundle into and out of decode_dense_pipe
//
// Purpose: groups the producer-side (in_*) and consumer-side (out_*) signals of
// the decode -> dense elastic pipeline so they travel as one port.
// Ports (as interface members):
//   in_valid / in_ready          producer handshake
//   act_type .. backprop_controll  bundle offered by the decoder
//   out_valid / out_ready        consumer handshake
//   *_out, load_w_out            head-stage bundle presented to the dense layer
// Modports:
//   master - the environment side (drives inputs and out_ready)
//   slave  - the pipeline side
interface decode_dense_pipe_if #(
  parameter int size                   = 3,
  parameter int data_size              = 16,
  parameter int cost_type_size         = 8,
  parameter int dense_type_size        = 4,
  parameter int act_type_size          = 4,
  parameter int backprop_controll_size = 66
);
  logic                              in_valid;
  logic                              in_ready;
  logic [act_type_size-1:0]          act_type;
  logic [dense_type_size-1:0]        dense_type;
  logic [cost_type_size-1:0]         cost_type;
  logic [data_size*size-1:0]         w;
  logic [data_size*size-1:0]         x;
  logic [data_size*size-1:0]         label_in;
  logic                              load_w;
  logic [backprop_controll_size-1:0] backprop_controll;

  logic                              out_valid;
  logic                              out_ready;
  logic [act_type_size-1:0]          act_type_out;
  logic [dense_type_size-1:0]        dense_type_out;
  logic [cost_type_size-1:0]         cost_type_out;
  logic [data_size*size-1:0]         w_out;
  logic [data_size*size-1:0]         x_out;
  logic [data_size*size-1:0]         label_out;
  logic                              load_w_out;
  logic [backprop_controll_size-1:0] backprop_controll_out;

  modport master (
    output in_valid, act_type, dense_type, cost_type, w, x, label_in, load_w,
           backprop_controll, out_ready,
    input  in_ready, out_valid, act_type_out, dense_type_out, cost_type_out,
           w_out, x_out, label_out, load_w_out, backprop_controll_out
  );

  modport slave (
    input  in_valid, act_type, dense_type, cost_type, w, x, label_in, load_w,
           backprop_controll, out_ready,
    output in_ready, out_valid, act_type_out, dense_type_out, cost_type_out,
           w_out, x_out, label_out, load_w_out, backprop_controll_out
  );
endinterface

// File: rtl/decode_dense_pipe.sv
// rtl/decode_dense_pipe.sv - elastic multi-stage pipeline for the decode bundle feeding the dense layer
//
// Purpose: depth-stage valid/ready pipeline; each stage advances on its own so
// bubbles collapse and full throughput is kept while the consumer stalls.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high, clears valid bits, data and occupancy
//   flush      synchronous, invalidates every stage and drops a same-cycle input
//   bus        decode_dense_pipe_if.slave handshake bus (in_* side, out_* side)
//   occupancy  registered count of valid stages
module decode_dense_pipe #(
  parameter int size                   = 3,
  parameter int data_size              = 16,
  parameter int cost_type_size         = 8,
  parameter int dense_type_size        = 4,
  parameter int act_type_size          = 4,
  parameter int backprop_controll_size = 66,
  parameter int depth                  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  decode_dense_pipe_if.slave           bus,
  output logic [$clog2(depth+1)-1:0]   occupancy
);
  localparam int vec_w    = size * data_size;
  localparam int bundle_w = act_type_size + dense_type_size + cost_type_size
                          + 3 * vec_w + 1 + backprop_controll_size;
  localparam int occ_w    = $clog2(depth + 1);

  typedef logic [bundle_w-1:0] bundle_t;

  bundle_t          data_q [depth];
  bundle_t          data_d [depth];
  logic [depth-1:0] valid_q;
  logic [depth-1:0] valid_d;
  logic [depth-1:0] adv;
  logic [occ_w-1:0] occ_q;
  logic [occ_w-1:0] occ_d;
  logic             in_fire;
  logic             out_fire;
  logic             head_load_w;
  bundle_t          in_bundle;

  assign in_bundle = {bus.act_type, bus.dense_type, bus.cost_type, bus.w, bus.x,
                      bus.label_in, bus.load_w, bus.backprop_controll};

  // Ready chain, walked from the head back to the entry. A running OR keeps
  // each adv bit from depending on another bit of the same vector.
  always_comb begin : ready_chain
    logic chain;
    chain = bus.out_ready;
    adv   = '0;
    for (int k = depth - 1; k >= 0; k--) begin
      chain  = chain | ~valid_q[k];
      adv[k] = chain;
    end
  end

  assign in_fire  = bus.in_valid & adv[0];
  assign out_fire = valid_q[depth-1] & bus.out_ready;

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < depth; k++) begin
      data_d[k] = data_q[k];
    end
    if (adv[0]) begin
      data_d[0]  = in_bundle;
      valid_d[0] = in_fire;
    end
    for (int k = 1; k < depth; k++) begin
      if (adv[k]) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
    // Flush wins over any advance, including the entry handshake.
    if (flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_fire && !out_fire) begin
      occ_d = occ_q + occ_w'(1);
    end else if (out_fire && !in_fire) begin
      occ_d = occ_q - occ_w'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < depth; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int k = 0; k < depth; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign {bus.act_type_out, bus.dense_type_out, bus.cost_type_out, bus.w_out,
          bus.x_out, bus.label_out, head_load_w,
          bus.backprop_controll_out} = data_q[depth-1];

  assign bus.in_ready   = adv[0];
  assign bus.out_valid  = valid_q[depth-1];
  // The head register may hold a stale strobe while invalid; never let it out.
  assign bus.load_w_out = head_load_w & valid_q[depth-1];
  assign occupancy      = occ_q;
endmodule

// File: tb/tb_decode_dense_pipe.sv
// tb/tb_decode_dense_pipe.sv - directed self-checking bench for decode_dense_pipe
module tb_decode_dense_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush;
  logic [1:0] occ2;
  logic [1:0] occ3;
  logic [2:0] occ4;
  int checks = 0;
  int errors = 0;

  localparam logic [47:0] ONES = {3{16'h0001}};

  decode_dense_pipe_if b2 ();
  decode_dense_pipe_if b3 ();
  decode_dense_pipe_if b4 ();

  decode_dense_pipe #(.depth(2)) u_d2 (.clk(clk), .reset(rst), .flush(flush), .bus(b2.slave), .occupancy(occ2));
  decode_dense_pipe #(.depth(3)) u_d3 (.clk(clk), .reset(rst), .flush(flush), .bus(b3.slave), .occupancy(occ3));
  decode_dense_pipe #(.depth(4)) u_d4 (.clk(clk), .reset(rst), .flush(flush), .bus(b4.slave), .occupancy(occ4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    b2.in_valid = 0; b2.act_type = 4'h1; b2.dense_type = 4'h2; b2.cost_type = 8'h3;
    b2.w = 48'h0; b2.x = 48'h0; b2.label_in = 48'h0; b2.load_w = 0;
    b2.backprop_controll = 66'h0; b2.out_ready = 0;
    b3.in_valid = 0; b3.act_type = 4'h4; b3.dense_type = 4'h5; b3.cost_type = 8'h6;
    b3.w = 48'h0; b3.x = 48'h0; b3.label_in = 48'h0; b3.load_w = 0;
    b3.backprop_controll = 66'h0; b3.out_ready = 0;
    b4.in_valid = 0; b4.act_type = 4'h7; b4.dense_type = 4'h8; b4.cost_type = 8'h9;
    b4.w = 48'h0; b4.x = 48'h0; b4.label_in = 48'h0; b4.load_w = 0;
    b4.backprop_controll = 66'h0; b4.out_ready = 0;
  endtask

  task automatic test_reset;
    checks++; if (b2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", b2.out_valid); end
    checks++; if (occ2 !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occ2); end
    checks++; if (b2.x_out !== 48'h0) begin errors++; $display("FAIL reset_x_out: got %0h expected 0", b2.x_out); end
    checks++; if (b2.act_type_out !== 4'h0) begin errors++; $display("FAIL reset_act_type_out: got %0h expected 0", b2.act_type_out); end
    rst = 0;
    tick;
    b2.out_ready = 0; b2.in_valid = 1; b2.load_w = 1; b2.x = 48'hA;
    tick;
    b2.x = 48'hB;
    tick;
    b2.in_valid = 0; b2.load_w = 0;
    checks++; if (occ2 !== 2'd2) begin errors++; $display("FAIL midstream_occupancy: got %0d expected 2", occ2); end
    checks++; if (b2.load_w_out !== 1'b1) begin errors++; $display("FAIL midstream_load_w_out: got %0b expected 1", b2.load_w_out); end
    #2 rst = 1;
    #1;
    checks++; if (b2.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid: got %0b expected 0", b2.out_valid); end
    checks++; if (occ2 !== 2'd0) begin errors++; $display("FAIL async_reset_occupancy: got %0d expected 0", occ2); end
    checks++; if (b2.x_out !== 48'h0) begin errors++; $display("FAIL async_reset_x_out: got %0h expected 0", b2.x_out); end
    checks++; if (b2.load_w_out !== 1'b0) begin errors++; $display("FAIL async_reset_load_w_out: got %0b expected 0", b2.load_w_out); end
    #1 rst = 0;
    b2.out_ready = 1; b2.in_valid = 1; b2.x = ONES;
    tick;
    b2.in_valid = 0;
    checks++; if (b2.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_edge1_valid: got %0b expected 0", b2.out_valid); end
    tick;
    checks++; if (b2.out_valid !== 1'b1) begin errors++; $display("FAIL post_reset_edge2_valid: got %0b expected 1", b2.out_valid); end
    checks++; if (b2.x_out !== ONES) begin errors++; $display("FAIL post_reset_x_out: got %0h expected %0h", b2.x_out, ONES); end
    tick;
    checks++; if (b2.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_drain: got %0b expected 0", b2.out_valid); end
  endtask

  task automatic test_streaming;
    logic exp_v;
    b3.out_ready = 1;
    for (int c = 0; c < 14; c++) begin
      b3.in_valid = (c < 10);
      b3.x = 48'(c);
      tick;
      exp_v = (c >= 2 && c <= 11);
      checks++; if (b3.out_valid !== exp_v) begin errors++; $display("FAIL stream_valid edge %0d: got %0b expected %0b", c, b3.out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (b3.x_out !== 48'(c - 2)) begin errors++; $display("FAIL stream_x edge %0d: got %0h expected %0h", c, b3.x_out, c - 2); end
      end
      if (c >= 2 && c <= 9) begin
        checks++; if (occ3 !== 2'd3) begin errors++; $display("FAIL stream_occupancy edge %0d: got %0d expected 3", c, occ3); end
      end
    end
    b3.in_valid = 0;
    b3.out_ready = 0;
  endtask

  task automatic test_backpressure;
    b2.out_ready = 0; b2.in_valid = 1; b2.x = 48'h10;
    tick;
    b2.x = 48'h11;
    tick;
    b2.x = 48'h12;
    #1;
    checks++; if (b2.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %0b expected 0", b2.in_ready); end
    checks++; if (occ2 !== 2'd2) begin errors++; $display("FAIL bp_occupancy: got %0d expected 2", occ2); end
    checks++; if (b2.x_out !== 48'h10) begin errors++; $display("FAIL bp_head_hold: got %0h expected 10", b2.x_out); end
    b2.out_ready = 1;
    #1;
    checks++; if (b2.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_same_cycle: got %0b expected 1", b2.in_ready); end
    tick;
    b2.in_valid = 0;
    checks++; if (b2.out_valid !== 1'b1 || b2.x_out !== 48'h11) begin errors++; $display("FAIL bp_second: got valid %0b x %0h expected 1/11", b2.out_valid, b2.x_out); end
    tick;
    checks++; if (b2.out_valid !== 1'b1 || b2.x_out !== 48'h12) begin errors++; $display("FAIL bp_third: got valid %0b x %0h expected 1/12", b2.out_valid, b2.x_out); end
    tick;
    checks++; if (b2.out_valid !== 1'b0 || occ2 !== 2'd0) begin errors++; $display("FAIL bp_drained: got valid %0b occ %0d expected 0/0", b2.out_valid, occ2); end
  endtask

  task automatic test_bubble;
    b4.out_ready = 0; b4.in_valid = 1; b4.x = 48'hA;
    tick;
    b4.in_valid = 0;
    tick;
    tick;
    b4.in_valid = 1; b4.x = 48'hB;
    tick;
    b4.in_valid = 0;
    checks++; if (occ4 !== 3'd2) begin errors++; $display("FAIL bubble_occ_after_push: got %0d expected 2", occ4); end
    tick;
    tick;
    tick;
    checks++; if (b4.out_valid !== 1'b1 || b4.x_out !== 48'hA) begin errors++; $display("FAIL bubble_head: got valid %0b x %0h expected 1/a", b4.out_valid, b4.x_out); end
    checks++; if (occ4 !== 3'd2) begin errors++; $display("FAIL bubble_occ_hold: got %0d expected 2", occ4); end
    b4.out_ready = 1;
    tick;
    checks++; if (b4.out_valid !== 1'b1 || b4.x_out !== 48'hB) begin errors++; $display("FAIL bubble_adjacent: got valid %0b x %0h expected 1/b", b4.out_valid, b4.x_out); end
    tick;
    checks++; if (b4.out_valid !== 1'b0 || occ4 !== 3'd0) begin errors++; $display("FAIL bubble_drain: got valid %0b occ %0d expected 0/0", b4.out_valid, occ4); end
    b4.out_ready = 0;
  endtask

  task automatic test_flush;
    int seen;
    b3.out_ready = 0; b3.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      b3.x = 48'(32 + i);
      tick;
    end
    checks++; if (occ3 !== 2'd3) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 3", occ3); end
    checks++; if (b3.x_out !== 48'd32) begin errors++; $display("FAIL flush_pre_head: got %0h expected 20", b3.x_out); end
    flush = 1; b3.x = 48'h99;
    tick;
    flush = 0; b3.in_valid = 0;
    checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b expected 0", b3.out_valid); end
    checks++; if (occ3 !== 2'd0) begin errors++; $display("FAIL flush_occupancy: got %0d expected 0", occ3); end
    b3.out_ready = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (b3.out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_dropped_input: got %0d valid cycles expected 0", seen); end
    b3.out_ready = 0;
  endtask

  task automatic test_load_w;
    int xfers;
    int pulses;
    b2.out_ready = 0; b2.in_valid = 1; b2.load_w = 1; b2.x = 48'h7;
    tick;
    b2.in_valid = 0;
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++; if (b2.load_w_out !== 1'b1 || b2.x_out !== 48'h7) begin errors++; $display("FAIL loadw_stall cycle %0d: got lw %0b x %0h expected 1/7", i, b2.load_w_out, b2.x_out); end
      tick;
    end
    b2.out_ready = 1;
    xfers = 0; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (b2.out_valid && b2.out_ready) xfers++;
      if (b2.load_w_out && b2.out_ready) pulses++;
      tick;
    end
    checks++; if (xfers !== 1) begin errors++; $display("FAIL loadw_transfers: got %0d expected 1", xfers); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL loadw_pulses: got %0d expected 1", pulses); end
    checks++; if (b2.out_valid !== 1'b0 || b2.load_w_out !== 1'b0) begin errors++; $display("FAIL loadw_stale_masked: got valid %0b lw %0b expected 0/0", b2.out_valid, b2.load_w_out); end
    b2.load_w = 0;
    b2.out_ready = 0;
  endtask

  initial begin
    rst = 1;
    flush = 0;
    idle_all();
    tick;
    tick;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_load_w();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_dense_pipe.md
# decode_dense_pipe

Parametrised elastic pipeline carrying the decode bundle (activation/dense/cost type codes, weight, load-weight strobe, input, label, backprop control) from the decoder into the dense layer. It replaces the fixed one-cycle delay stage: depth is configurable, and a valid/ready handshake provides backpressure. It also supports a synchronous flush and an occupancy count. Every stage advances independently, so bubbles collapse and full throughput is kept under stalls.

## Interface
Parameters:
- size, 3, channels per vector bus (w, x, label)
- data_size, 16, bits per channel
- cost_type_size, 8, cost type code width
- dense_type_size, 4, dense type code width
- act_type_size, 4, activation type code width
- backprop_controll_size, 66, backprop control word width
- depth, 2, pipeline stages; legal range 1..16

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all stages
- flush  in  1  synchronous; invalidates all stages
- in_valid  in  1  input bundle valid
- in_ready  out  1  pipeline accepts input this cycle
- act_type, dense_type, cost_type  in  act_type_size / dense_type_size / cost_type_size  type codes
- w, x, label_in  in  data_size*size each  vector buses
- load_w  in  1  weight-load strobe
- backprop_controll  in  backprop_controll_size  backprop control word
- out_valid  out  1  head stage valid
- out_ready  in  1  consumer accepts head this cycle
- act_type_out, dense_type_out, cost_type_out, w_out, x_out, label_out, backprop_controll_out  out  same widths as the inputs  head stage contents
- load_w_out  out  1  head load_w AND out_valid
- occupancy  out  $clog2(depth+1)  number of valid stages

## Operation
- Each stage k (0 = entry, depth-1 = head) holds a valid bit plus the full bundle register. All fields travel together.
- Head advance: adv[depth-1] = !valid[depth-1] | out_ready.
- Stage advance: adv[k] = !valid[k] | adv[k+1]. This is a combinational ready chain.
- in_ready = adv[0]. A transfer occurs when in_valid & in_ready.
- On a clock edge where adv[k] holds:
  - Stage k loads stage k-1, or the input for k = 0.
  - The loaded valid is valid[k-1], or in_valid & in_ready for k = 0.
- A stage whose adv is low holds both its data and its valid bit.
- Data registers of invalid stages may load garbage. Outputs are meaningful only while out_valid = 1. The exception is load_w_out, which is forced to 0 when out_valid = 0.
- flush = 1 at an edge:
  - All valid bits clear.
  - An input handshaking in the same cycle is dropped.
  - Data registers are don't-care.
  - occupancy becomes 0 on the next cycle.
- occupancy is a registered counter.
  - It increments on an accepted input with no output transfer.
  - It decrements on an output transfer (out_valid & out_ready) with no accepted input.
  - It is unchanged when both or neither occur.
  - It is forced to 0 by flush or reset.
- Invariant: occupancy equals the popcount of the valid bits. It never exceeds depth and never underflows.
- Full with out_ready = 1: the head drains and the whole chain shifts, so in_ready = 1 in the same cycle (zero-bubble).

## Timing
- Reset, asynchronous: all valid bits, all data registers and occupancy go to 0. Consequently out_valid = 0, load_w_out = 0 and every *_out = 0 during and after reset until the first load.
- Reset asserted mid-operation discards all in-flight bundles immediately, without waiting for a clock edge.
- Latency with no stall: an input accepted at edge N is presented on the outputs after edge N+depth-1. It is visible in the cycle following edge N+depth-1, i.e. depth edges including the accept edge.
- Throughput: one bundle per cycle while out_ready = 1.
- Stall: while out_valid = 1 and out_ready = 0, the head outputs are held stable. Upstream bubbles are still filled.
- Combinational paths: out_ready → in_ready. There is no combinational path from in_valid or data to any output.
- Ordering: bundles exit in acceptance order with none duplicated. load_w_out pulses exactly once per accepted load_w = 1 bundle.

## Test plan
- Reset: assert reset mid-stream with depth = 2 and 2 bundles in flight → out_valid = 0, occupancy = 0 and all *_out = 0 immediately. After release, the first accepted bundle (x = 16'h0001 ×3) appears after 2 edges.
- Streaming: depth = 3, out_ready = 1, in_valid = 1 for 10 cycles with x = i → outputs x = 0..9 on consecutive cycles, starting 3 edges after the first accept. occupancy stays at 3 in steady state.
- Backpressure: depth = 2, out_ready = 0, push 3 bundles → occupancy = 2 and in_ready = 0 on the 3rd. The head holds bundle 0. Raise out_ready → in_ready = 1 in the same cycle, and bundles 0, 1, 2 exit in order with no gap.
- Bubble collapse: depth = 4, push A, idle 2 cycles, push B while out_ready = 0 → A at the head, and B reaches stage 2 adjacent to A. occupancy = 2.
- Flush: depth = 3, 3 stages valid, flush together with in_valid = 1 → the next cycle has out_valid = 0 and occupancy = 0. The bundle offered during the flush cycle never appears.
- load_w: bundle with load_w = 1 stalled at the head for 5 cycles → load_w_out = 1 for those 5 cycles and exactly one transfer. load_w_out = 0 while out_valid = 0, even if a stale register bit is 1.
